// File: rtl/gf_sram_arbiter.sv
// Two-port arbiter in front of a single-port GF SRAM macro (round-robin + lock).
// Define GF_SRAM_ARB_FIXED_PRIORITY_EN to make port 0 win all contention.
module gf_sram_arbiter #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 9,
  parameter int MAX_LOCK  = 16
) (
  input  logic                 UserCLK,
  input  logic                 RESET_N,
  input  logic                 CONFIGURED_top,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic                 p0_lock,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic [WIDTH-1:0]     p0_wdata,
  input  logic [WIDTH-1:0]     p0_wmask,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [WIDTH-1:0]     p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic                 p1_lock,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic [WIDTH-1:0]     p1_wdata,
  input  logic [WIDTH-1:0]     p1_wmask,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [WIDTH-1:0]     p1_rdata,
  output logic                 CEN_SRAM,
  output logic                 GWEN_SRAM,
  output logic [WIDTH-1:0]     WEN_SRAM,
  output logic [ADDR_BITS-1:0] A_SRAM,
  output logic [WIDTH-1:0]     D_SRAM,
  input  logic [WIDTH-1:0]     Q_SRAM,
  output logic                 CLK_SRAM
);

  typedef enum logic {
    WAIT_CFG = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  state_t               state;
  logic                 last;
  logic                 lock_port;
  logic [7:0]           lock_cnt;
  logic [ADDR_BITS-1:0] a_q;
  logic [WIDTH-1:0]     d_q;
  logic                 rv0;
  logic                 rv1;
  logic [WIDTH-1:0]     rd0_q;
  logic [WIDTH-1:0]     rd1_q;

  logic                 run;
  logic                 locked;
  logic                 hold0;
  logic                 hold1;
  logic                 free;
  logic                 prio0;
  logic                 g0;
  logic                 g1;
  logic                 gnt;
  logic                 w_we;
  logic                 w_lock;
  logic [ADDR_BITS-1:0] w_addr;
  logic [WIDTH-1:0]     w_wdata;
  logic [WIDTH-1:0]     w_wmask;
  logic [7:0]           cnt_nxt;

  // A nonzero lock count means lock_port owns this arbitration.
  always_comb begin
    run    = (state == RUN) && CONFIGURED_top;
    locked = lock_cnt != 8'd0;
    hold0  = locked && !lock_port && p0_req;
`ifdef GF_SRAM_ARB_FIXED_PRIORITY_EN
    hold1  = locked && lock_port && p1_req && !p0_req;
    prio0  = 1'b1;
`else
    hold1  = locked && lock_port && p1_req;
    prio0  = last;
`endif
    free   = !hold0 && !hold1;
    g0     = 1'b0;
    g1     = 1'b0;
    if (run) begin
      unique case (1'b1)
        hold0: g0 = 1'b1;
        hold1: g1 = 1'b1;
        free && p0_req && p1_req: begin
          g0 = prio0;
          g1 = !prio0;
        end
        free && p0_req && !p1_req: g0 = 1'b1;
        free && !p0_req && p1_req: g1 = 1'b1;
        default: ;
      endcase
    end
    gnt     = g0 || g1;
    w_we    = g1 ? p1_we    : p0_we;
    w_lock  = g1 ? p1_lock  : p0_lock;
    w_addr  = g1 ? p1_addr  : p0_addr;
    w_wdata = g1 ? p1_wdata : p0_wdata;
    w_wmask = g1 ? p1_wmask : p0_wmask;
    cnt_nxt = (locked && (lock_port == g1)) ? lock_cnt + 8'd1 : 8'd1;
  end

  assign p0_gnt    = g0;
  assign p1_gnt    = g1;
  assign CEN_SRAM  = !gnt;
  assign GWEN_SRAM = !(gnt && w_we);
  assign WEN_SRAM  = (gnt && w_we) ? ~w_wmask : '1;
  assign A_SRAM    = gnt ? w_addr  : a_q;
  assign D_SRAM    = gnt ? w_wdata : d_q;
  assign p0_rvalid = rv0;
  assign p1_rvalid = rv1;
  assign p0_rdata  = rv0 ? Q_SRAM : rd0_q;
  assign p1_rdata  = rv1 ? Q_SRAM : rd1_q;
  assign CLK_SRAM  = UserCLK;

  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= WAIT_CFG;
    end else begin
      unique case (state)
        WAIT_CFG: if (CONFIGURED_top) state <= RUN;
        RUN:      if (!CONFIGURED_top) state <= WAIT_CFG;
      endcase
    end
  end

  // Reaching LOCK_MAX drops ownership so the other port gets one turn.
  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last      <= 1'b1;
      lock_port <= 1'b0;
      lock_cnt  <= 8'd0;
      a_q       <= '0;
      d_q       <= '0;
    end else if (gnt) begin
      last <= g1;
      a_q  <= w_addr;
      d_q  <= w_wdata;
      if (w_lock && (cnt_nxt < LOCK_MAX)) begin
        lock_port <= g1;
        lock_cnt  <= cnt_nxt;
      end else begin
        lock_cnt  <= 8'd0;
      end
    end else begin
      lock_cnt <= 8'd0;
    end
  end

  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rv0   <= 1'b0;
      rv1   <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      rv0 <= g0 && !p0_we;
      rv1 <= g1 && !p1_we;
      if (rv0) rd0_q <= Q_SRAM;
      if (rv1) rd1_q <= Q_SRAM;
    end
  end

endmodule

// File: doc/gf_sram_arbiter.md
GF_SRAM_ARBITER -- requirements
Module: gf_sram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data/write-mask width.
REQ-002 SHALL have parameter ADDR_BITS, default 9, SRAM address width.
REQ-003 SHALL have parameter MAX_LOCK, default 16, maximum consecutive cycles a port may hold the grant; legal range 1 to 255.
REQ-004 SHALL have one clock and one reset. UserCLK is the clock and the only clock. RESET_N is reset: asynchronous and active-low.
REQ-005 SHALL have these ports, one per line: name direction width meaning.
- UserCLK in 1: clock; the SRAM samples on the rising edge.
- RESET_N in 1: asynchronous active-low reset.
- CONFIGURED_top in 1: fabric configured; access is enabled only when this is 1.
- pN_req in 1: port N (N=0,1) access request.
- pN_we in 1: 1=write, 0=read.
- pN_lock in 1: keep ownership for the next cycle.
- pN_addr in ADDR_BITS: access address.
- pN_wdata in WIDTH: write data.
- pN_wmask in WIDTH: per-bit write enable, active-high.
- pN_gnt out 1: request accepted this cycle.
- pN_rvalid out 1: read data valid.
- pN_rdata out WIDTH: read data, held until the next read by that port.
- CEN_SRAM out 1: chip enable, active-low.
- GWEN_SRAM out 1: global write enable, active-low.
- WEN_SRAM out WIDTH: bit write enables, active-low.
- A_SRAM out ADDR_BITS: SRAM address.
- D_SRAM out WIDTH: SRAM write data.
- Q_SRAM in WIDTH: SRAM read data, valid in the cycle after the access edge.
- CLK_SRAM out 1: equals UserCLK.

Function
REQ-006 SHALL implement a 2-state FSM:
- WAIT_CFG to RUN on the edge where CONFIGURED_top=1.
- RUN to WAIT_CFG on any edge where CONFIGURED_top=0.
REQ-007 In WAIT_CFG the block SHALL drive CEN_SRAM=1, GWEN_SRAM=1, WEN_SRAM all-ones and pN_gnt=0.
REQ-008 In RUN, the winner SHALL be selected combinationally from pN_req and the arbitration state. pN_gnt=1 for that port only. SRAM pins SHALL follow the winner in the same cycle:
- CEN_SRAM=0.
- GWEN_SRAM=~we.
- WEN_SRAM=~wmask for writes, all-ones for reads.
- A_SRAM=addr and D_SRAM=wdata.
REQ-009 With no request in RUN, CEN_SRAM SHALL be 1; A_SRAM and D_SRAM hold their last values.
REQ-010 Default arbitration SHALL be round-robin. A single requester wins. When both request, the port not granted last wins. The last-granted pointer updates only on a grant.
REQ-011 Lock behaviour:
- If the winner has pN_lock=1, it SHALL own the next cycle regardless of the other request.
- An 8-bit lock counter increments per locked grant.
- Once it reaches MAX_LOCK, ownership SHALL be released for one arbitration and the counter cleared.
- The counter SHALL clear on any unlocked grant or idle cycle.
REQ-012 If the lock owner drops pN_req, the lock SHALL end immediately and normal arbitration applies that cycle.
REQ-013 A granted read SHALL assert pN_rvalid for exactly one cycle, the cycle after the grant. pN_rdata SHALL equal Q_SRAM in that cycle and be registered and held afterwards.
REQ-014 Writes SHALL produce no rvalid. A read after a write to the same address on the next cycle SHALL return the written data.
REQ-015 A read in flight when CONFIGURED_top falls SHALL still complete its rvalid cycle.

Reset
REQ-016 When RESET_N=0 the block SHALL asynchronously enter this state:
- FSM in WAIT_CFG.
- Pointer selects port 0 as next winner.
- Lock counter=0.
- pN_gnt=0, pN_rvalid=0, pN_rdata=0.
- CEN_SRAM=1, GWEN_SRAM=1, WEN_SRAM all-ones, A_SRAM=0, D_SRAM=0.
REQ-017 Reset SHALL deassert with no spurious SRAM access. The first access SHALL occur no earlier than the second UserCLK edge after RESET_N rises with CONFIGURED_top=1.

Configuration
REQ-018 When macro GF_SRAM_ARB_FIXED_PRIORITY_EN is defined, port 0 SHALL always win contention. Lock still applies, but a lock by port 1 SHALL be ignored while p0_req=1.
REQ-019 Without GF_SRAM_ARB_FIXED_PRIORITY_EN, the round-robin behaviour of REQ-010 applies.

Verification
REQ-020 Reset, then CONFIGURED_top=0 with p0_req=1 for 5 cycles -> CEN_SRAM=1 and p0_gnt=0 throughout.
REQ-021 Configured; p0 writes addr 0x1A5, data 0x3C, mask 0xFF; next cycle p1 reads 0x1A5 -> p1_rvalid=1 one cycle later and p1_rdata=0x3C, held afterwards.
REQ-022 Both ports continuously request reads, no lock -> grants alternate p0,p1,p0,p1 (round-robin build).
REQ-023 p1 requests with lock held, MAX_LOCK=4, p0 requesting -> p1 granted 4 cycles, then p0 granted 1 cycle.
REQ-024 Fixed-priority build, both request continuously -> p0_gnt=1 every cycle and p1_gnt=0; RESET_N pulsed low mid-read -> p0_rvalid=0 and CEN_SRAM=1 immediately.
